// File: rtl/lsu_mem_master.sv
// Load/store master for a big-endian byte-array DM: word-aligned accesses, sub-word RMW stores.
// Optional range check enabled by defining LSU_BOUNDS_CHECK_EN.
module lsu_mem_master #(
    parameter int MEM_BYTES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWriteData,
    output logic        MemWrite,
    input  logic [31:0] MemReadData,
    output logic [1:0]  o_dbg_state
);

    // Handshake: a request transfers on a posedge where req_valid & req_ready; req_ready is
    // high only in IDLE, and exactly one resp_valid pulse answers each transferred request.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_WRITE = 2'd2, S_RESP = 2'd3} state_t;

    if ((MEM_BYTES % 4) != 0) begin : g_bad_mem_bytes
        $error("MEM_BYTES must be a multiple of 4");
    end

    state_t      r_state, w_next;
    logic        r_write, r_unsigned, r_err, r_mem_write;
    logic [1:0]  r_size, r_off;
    logic [31:0] r_wdata, r_rdata, r_mem_addr, r_mem_wdata;

    logic        w_accept, w_req_err, w_word_store;
    logic [4:0]  w_bsh, w_hsh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_merged, w_extract;

    assign w_accept     = req_valid && req_ready;
    assign w_word_store = req_write && (req_size == 2'd2);

    always_comb begin
        w_req_err = 1'b0;
        unique case (req_size)
            2'd0:    w_req_err = 1'b0;
            2'd1:    w_req_err = req_addr[0];
            2'd2:    w_req_err = (req_addr[1:0] != 2'b00);
            default: w_req_err = 1'b1;
        endcase
`ifdef LSU_BOUNDS_CHECK_EN
        begin
            logic [32:0] w_nbytes, w_end;
            w_nbytes = (req_size == 2'd0) ? 33'd1 : (req_size == 2'd1) ? 33'd2 : 33'd4;
            w_end    = {1'b0, req_addr} + w_nbytes;
            if (w_end > 33'(MEM_BYTES)) w_req_err = 1'b1;
        end
`endif
    end

    // Big-endian lanes: byte offset k sits at bit 24-8k, so the shift is (3-k)*8.
    assign w_bsh  = {~r_off, 3'b000};
    assign w_hsh  = r_off[1] ? 5'd0 : 5'd16;
    assign w_byte = 8'(MemReadData >> w_bsh);
    assign w_half = 16'(MemReadData >> w_hsh);

    always_comb begin
        w_merged  = r_wdata;
        w_extract = MemReadData;
        unique case (r_size)
            2'd0: begin
                w_merged  = (MemReadData & ~(32'h0000_00FF << w_bsh)) | ({24'b0, r_wdata[7:0]} << w_bsh);
                w_extract = r_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            2'd1: begin
                w_merged  = (MemReadData & ~(32'h0000_FFFF << w_hsh)) | ({16'b0, r_wdata[15:0]} << w_hsh);
                w_extract = r_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            end
            default: begin
                w_merged  = r_wdata;
                w_extract = MemReadData;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_req_err)         w_next = S_RESP;
                    else if (w_word_store) w_next = S_WRITE;
                    else                   w_next = S_READ;
                end
            end
            S_READ:  w_next = r_write ? S_WRITE : S_RESP;
            S_WRITE: w_next = S_RESP;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready   = (r_state == S_IDLE);
        resp_valid  = (r_state == S_RESP);
        resp_error  = (r_state == S_RESP) && r_err;
        o_dbg_state = r_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write     <= 1'b0;
            r_unsigned  <= 1'b0;
            r_err       <= 1'b0;
            r_size      <= 2'd0;
            r_off       <= 2'd0;
            r_wdata     <= 32'd0;
            r_rdata     <= 32'd0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_write <= 1'b0;
        end else begin
            r_mem_write <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_write    <= req_write;
                        r_unsigned <= req_unsigned;
                        r_size     <= req_size;
                        r_off      <= req_addr[1:0];
                        r_wdata    <= req_wdata;
                        r_err      <= w_req_err;
                        if (w_req_err || req_write) r_rdata <= 32'd0;
                        // An erroring request leaves the DM port untouched.
                        if (!w_req_err) begin
                            r_mem_addr <= {req_addr[31:2], 2'b00};
                            if (w_word_store) begin
                                r_mem_write <= 1'b1;
                                r_mem_wdata <= req_wdata;
                            end
                        end
                    end
                end
                S_READ: begin
                    if (r_write) begin
                        r_mem_write <= 1'b1;
                        r_mem_wdata <= w_merged;
                    end else begin
                        r_rdata <= w_extract;
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp_rdata   = r_rdata;
    assign MemAddr      = r_mem_addr;
    assign MemWriteData = r_mem_wdata;
    assign MemWrite     = r_mem_write;

endmodule
